// File: rtl/ex_alu_cdb_tx_pkg.sv
// Shared definitions for the ALU execute lane / result transmitter: op encodings and the free-tag value.
package ex_alu_cdb_tx_pkg;

    localparam int OP_W_DEF     = 6;
    localparam int TAG_FREE_VAL = 0;

    typedef enum logic [OP_W_DEF-1:0] {
        OP_NOP   = 6'd0,
        OP_ADD   = 6'd1,
        OP_SUB   = 6'd2,
        OP_AND   = 6'd3,
        OP_OR    = 6'd4,
        OP_XOR   = 6'd5,
        OP_SLL   = 6'd6,
        OP_SRL   = 6'd7,
        OP_SRA   = 6'd8,
        OP_SLT   = 6'd9,
        OP_SLTU  = 6'd10,
        OP_LUI   = 6'd11,
        OP_AUIPC = 6'd12,
        OP_JAL   = 6'd13,
        OP_JALR  = 6'd14
    } alu_op_e;

endpackage

// File: rtl/ex_alu_cdb_tx_alu_core.sv
// Purely combinational ALU: op/src1/src2/pc -> result, all arithmetic modulo 2^DATA_W.
module ex_alu_cdb_tx_alu_core
    import ex_alu_cdb_tx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OP_W   = 6
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_src1,
    input  logic [DATA_W-1:0] i_src2,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [DATA_W-1:0] o_result
);

    logic signed [DATA_W-1:0] w_s1;
    logic signed [DATA_W-1:0] w_s2;
    logic        [4:0]        w_shamt;
    logic        [ADDR_W-1:0] w_link;

    assign w_s1    = i_src1;
    assign w_s2    = i_src2;
    assign w_shamt = i_src2[4:0];
    assign w_link  = i_pc + ADDR_W'(4);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_W'(OP_ADD):   o_result = i_src1 + i_src2;
            OP_W'(OP_SUB):   o_result = i_src1 - i_src2;
            OP_W'(OP_AND):   o_result = i_src1 & i_src2;
            OP_W'(OP_OR):    o_result = i_src1 | i_src2;
            OP_W'(OP_XOR):   o_result = i_src1 ^ i_src2;
            OP_W'(OP_SLL):   o_result = i_src1 << w_shamt;
            OP_W'(OP_SRL):   o_result = i_src1 >> w_shamt;
            OP_W'(OP_SRA):   o_result = w_s1 >>> w_shamt;
            OP_W'(OP_SLT):   o_result = {{(DATA_W-1){1'b0}}, (w_s1 < w_s2)};
            OP_W'(OP_SLTU):  o_result = {{(DATA_W-1){1'b0}}, (i_src1 < i_src2)};
            OP_W'(OP_LUI):   o_result = i_src2;
            OP_W'(OP_AUIPC): o_result = DATA_W'(i_pc) + i_src2;
            OP_W'(OP_JAL),
            OP_W'(OP_JALR):  o_result = DATA_W'(w_link);
            default:         o_result = '0;
        endcase
    end

endmodule

// File: rtl/ex_alu_cdb_tx.sv
// ALU execute lane with result FIFO and held CDB broadcast register.
// Optional ALU_CDB_BYPASS_EN: result skips the FIFO when it is empty and the output slot is free.
module ex_alu_cdb_tx
    import ex_alu_cdb_tx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              ex_alu_en,
    input  logic [DATA_W-1:0] ex_src1,
    input  logic [DATA_W-1:0] ex_src2,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [OP_W-1:0]   ex_aluop,
    input  logic [TAG_W-1:0]  ex_dest,
    input  logic              cdb_grant,
    output logic              en_alu_rst,
    output logic [TAG_W-1:0]  alu_rst_tag,
    output logic [DATA_W-1:0] alu_rst_data,
    output logic              alu_full,
    output logic              ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [TAG_W-1:0] TAG_FREE = TAG_W'(TAG_FREE_VAL);

    logic [TAG_W-1:0]  r_tag_mem  [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic              r_out_en;
    logic [TAG_W-1:0]  r_out_tag;
    logic [DATA_W-1:0] r_out_data;
    logic              r_ovf;

    logic [DATA_W-1:0] w_result;
    logic [PW-1:0]     w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_load;
    logic              w_push_req;
    logic              w_bypass;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf_set;
    logic              w_mem_we;
    logic [TAG_W-1:0]  w_head_tag;
    logic [DATA_W-1:0] w_head_data;

    ex_alu_cdb_tx_alu_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .OP_W   (OP_W)
    ) u_alu_core (
        .i_op     (ex_aluop),
        .i_src1   (ex_src1),
        .i_src2   (ex_src2),
        .i_pc     (ex_pc),
        .o_result (w_result)
    );

    assign w_count     = r_wptr - r_rptr;
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head_tag  = r_tag_mem[r_rptr[AW-1:0]];
    assign w_head_data = r_data_mem[r_rptr[AW-1:0]];

    // The output slot takes a new value when it is idle or its broadcast is granted now.
    assign w_load     = !r_out_en || cdb_grant;
    assign w_push_req = ex_alu_en && (ex_dest != TAG_FREE);

`ifdef ALU_CDB_BYPASS_EN
    assign w_bypass = w_push_req && w_empty && w_load;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pop     = w_load && !w_empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push    = w_push_req && !w_bypass && (!w_full || w_pop);
    assign w_ovf_set = w_push_req && !w_bypass && w_full && !w_pop;
    assign w_mem_we  = w_push && rdy && !clear;

    // One slot is held back for the issue already in flight from the picker.
    assign alu_full = (w_count >= PW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_tag_mem[r_wptr[AW-1:0]]  <= ex_dest;
            r_data_mem[r_wptr[AW-1:0]] <= w_result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_out_en   <= 1'b0;
            r_out_tag  <= TAG_FREE;
            r_out_data <= '0;
            r_ovf      <= 1'b0;
        end else if (clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_out_en   <= 1'b0;
            r_out_tag  <= TAG_FREE;
            r_out_data <= '0;
            r_ovf      <= 1'b0;
        end else if (rdy) begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_load) begin
                if (w_pop) begin
                    r_out_en   <= 1'b1;
                    r_out_tag  <= w_head_tag;
                    r_out_data <= w_head_data;
                end else if (w_bypass) begin
                    r_out_en   <= 1'b1;
                    r_out_tag  <= ex_dest;
                    r_out_data <= w_result;
                end else begin
                    r_out_en   <= 1'b0;
                    r_out_tag  <= TAG_FREE;
                    r_out_data <= '0;
                end
            end
        end
    end

    assign en_alu_rst   = r_out_en;
    assign alu_rst_tag  = r_out_tag;
    assign alu_rst_data = r_out_data;
    assign ovf_err      = r_ovf;

endmodule

// File: tb/tb_ex_alu_cdb_tx.sv
// Directed bench for ex_alu_cdb_tx: table of ALU vectors plus FIFO/grant/clear/reset sequences.
module tb_ex_alu_cdb_tx;
    import ex_alu_cdb_tx_pkg::*;

`ifdef ALU_CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        ex_alu_en;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic [31:0] ex_pc;
    logic [5:0]  ex_aluop;
    logic [3:0]  ex_dest;
    logic        cdb_grant;
    logic        en_alu_rst;
    logic [3:0]  alu_rst_tag;
    logic [31:0] alu_rst_data;
    logic        alu_full;
    logic        ovf_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] pc;
        logic [3:0]  dest;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    ex_alu_cdb_tx dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .clear        (clear),
        .ex_alu_en    (ex_alu_en),
        .ex_src1      (ex_src1),
        .ex_src2      (ex_src2),
        .ex_pc        (ex_pc),
        .ex_aluop     (ex_aluop),
        .ex_dest      (ex_dest),
        .cdb_grant    (cdb_grant),
        .en_alu_rst   (en_alu_rst),
        .alu_rst_tag  (alu_rst_tag),
        .alu_rst_data (alu_rst_data),
        .alu_full     (alu_full),
        .ovf_err      (ovf_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic en, input logic [5:0] op, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] pc, input logic [3:0] dest);
        ex_alu_en = en;
        ex_aluop  = op;
        ex_src1   = s1;
        ex_src2   = s2;
        ex_pc     = pc;
        ex_dest   = dest;
    endtask

    initial begin
        vecs[0]  = '{OP_ADD,   32'd5,          32'd7,          32'h0,          4'd2,  32'd12};
        vecs[1]  = '{OP_SUB,   32'd5,          32'd7,          32'h0,          4'd3,  32'hFFFF_FFFE};
        vecs[2]  = '{OP_AND,   32'hF0F0_00FF,  32'h0FF0_F00F,  32'h0,          4'd4,  32'h00F0_000F};
        vecs[3]  = '{OP_OR,    32'hF0F0_00FF,  32'h0FF0_F00F,  32'h0,          4'd5,  32'hFFF0_F0FF};
        vecs[4]  = '{OP_XOR,   32'hF0F0_00FF,  32'h0FF0_F00F,  32'h0,          4'd6,  32'hFF00_F0F0};
        vecs[5]  = '{OP_SLL,   32'd1,          32'h0000_003F,  32'h0,          4'd7,  32'h8000_0000};
        vecs[6]  = '{OP_SRL,   32'h8000_0000,  32'd4,          32'h0,          4'd8,  32'h0800_0000};
        vecs[7]  = '{OP_SRA,   32'h8000_0000,  32'd4,          32'h0,          4'd9,  32'hF800_0000};
        vecs[8]  = '{OP_SLT,   32'hFFFF_FFFF,  32'd1,          32'h0,          4'd10, 32'd1};
        vecs[9]  = '{OP_SLTU,  32'd1,          32'hFFFF_FFFF,  32'h0,          4'd11, 32'd1};
        vecs[10] = '{OP_LUI,   32'hDEAD_BEEF,  32'h1234_5000,  32'h0,          4'd12, 32'h1234_5000};
        vecs[11] = '{OP_AUIPC, 32'h0,          32'h0000_1000,  32'h0000_0100,  4'd13, 32'h0000_1100};
        vecs[12] = '{OP_JAL,   32'h0,          32'h0,          32'h0000_0200,  4'd14, 32'h0000_0204};
        vecs[13] = '{OP_JALR,  32'h55,         32'h0,          32'hFFFF_FFFC,  4'd15, 32'h0};
        vecs[14] = '{6'd63,    32'd5,          32'd7,          32'h0,          4'd1,  32'h0};
        vecs[15] = '{OP_NOP,   32'd5,          32'd7,          32'h0,          4'd2,  32'h0};

        rst = 1'b0; rdy = 1'b1; clear = 1'b0; cdb_grant = 1'b1;
        drive(1'b0, OP_NOP, 32'h0, 32'h0, 32'h0, 4'd0);
        step(); step();
        chk("reset_en", {31'd0, en_alu_rst}, 32'd0);
        chk("reset_tag", {28'd0, alu_rst_tag}, 32'd0);
        chk("reset_data", alu_rst_data, 32'd0);
        chk("reset_full", {31'd0, alu_full}, 32'd0);
        chk("reset_ovf", {31'd0, ovf_err}, 32'd0);
        rst = 1'b1;
        step();

        // ALU vectors, grant tied high
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].pc, vecs[i].dest);
            step();
            ex_alu_en = 1'b0;
            for (int k = 1; k < LAT; k++) step();
            chk($sformatf("vec%0d_en", i), {31'd0, en_alu_rst}, 32'd1);
            chk($sformatf("vec%0d_tag", i), {28'd0, alu_rst_tag}, {28'd0, vecs[i].dest});
            chk($sformatf("vec%0d_data", i), alu_rst_data, vecs[i].exp);
            step();
            chk($sformatf("vec%0d_released", i), {31'd0, en_alu_rst}, 32'd0);
        end

        // dest == TAG_FREE is discarded
        drive(1'b1, OP_ADD, 32'd1, 32'd1, 32'h0, 4'd0);
        step();
        ex_alu_en = 1'b0;
        step();
        chk("free_tag_dropped", {31'd0, en_alu_rst}, 32'd0);

        // fill with grant low, overflow, then drain in order
        cdb_grant = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            drive(1'b1, OP_ADD, 32'(t * 16), 32'd0, 32'h0, 4'(t));
            step();
            if (t == 3) chk("full_at_cnt2", {31'd0, alu_full}, 32'd0);
            if (t == 4) chk("full_at_cnt3", {31'd0, alu_full}, 32'd1);
        end
        chk("no_ovf_at_cnt4", {31'd0, ovf_err}, 32'd0);
        drive(1'b1, OP_ADD, 32'h60, 32'd0, 32'h0, 4'd6);
        step();
        ex_alu_en = 1'b0;
        chk("ovf_set", {31'd0, ovf_err}, 32'd1);
        chk("ovf_head_tag", {28'd0, alu_rst_tag}, 32'd1);
        chk("ovf_still_full", {31'd0, alu_full}, 32'd1);
        step();
        chk("hold_no_grant_tag", {28'd0, alu_rst_tag}, 32'd1);
        cdb_grant = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            chk($sformatf("drain%0d_en", t), {31'd0, en_alu_rst}, 32'd1);
            chk($sformatf("drain%0d_tag", t), {28'd0, alu_rst_tag}, 32'(t));
            chk($sformatf("drain%0d_data", t), alu_rst_data, 32'(t * 16));
            step();
        end
        chk("drain_done_en", {31'd0, en_alu_rst}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf_err}, 32'd1);

        // clear with two queued and one issuing
        cdb_grant = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            drive(1'b1, OP_ADD, 32'(t), 32'd0, 32'h0, 4'(t));
            step();
        end
        chk("pre_clear_en", {31'd0, en_alu_rst}, 32'd1);
        drive(1'b1, OP_ADD, 32'd4, 32'd0, 32'h0, 4'd4);
        clear = 1'b1;
        step();
        clear = 1'b0;
        ex_alu_en = 1'b0;
        chk("clear_en", {31'd0, en_alu_rst}, 32'd0);
        chk("clear_tag", {28'd0, alu_rst_tag}, 32'd0);
        chk("clear_data", alu_rst_data, 32'd0);
        chk("clear_ovf", {31'd0, ovf_err}, 32'd0);
        chk("clear_full", {31'd0, alu_full}, 32'd0);
        cdb_grant = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("clear_stale%0d", k), {31'd0, en_alu_rst}, 32'd0);
        end

        // rdy low freezes state and ignores grant and issue
        cdb_grant = 1'b0;
        drive(1'b1, OP_ADD, 32'd2, 32'd3, 32'h0, 4'd5);
        step();
        ex_alu_en = 1'b0;
        for (int k = 1; k < LAT; k++) step();
        chk("rdy_pre_en", {31'd0, en_alu_rst}, 32'd1);
        rdy = 1'b0;
        cdb_grant = 1'b1;
        drive(1'b1, OP_ADD, 32'd9, 32'd0, 32'h0, 4'd6);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rdy_hold%0d_en", k), {31'd0, en_alu_rst}, 32'd1);
            chk($sformatf("rdy_hold%0d_tag", k), {28'd0, alu_rst_tag}, 32'd5);
            chk($sformatf("rdy_hold%0d_data", k), alu_rst_data, 32'd5);
        end
        ex_alu_en = 1'b0;
        rdy = 1'b1;
        step();
        chk("rdy_release_en", {31'd0, en_alu_rst}, 32'd0);

        // async reset in the middle of a broadcast with ovf_err set
        cdb_grant = 1'b0;
        for (int t = 0; t < 6; t++) begin
            drive(1'b1, OP_ADD, 32'((t == 0) ? 3 : t + 7), 32'h100, 32'h0, 4'((t == 0) ? 3 : t + 7));
            step();
        end
        ex_alu_en = 1'b0;
        chk("mid_en", {31'd0, en_alu_rst}, 32'd1);
        chk("mid_tag", {28'd0, alu_rst_tag}, 32'd3);
        chk("mid_data", alu_rst_data, 32'h103);
        chk("mid_ovf", {31'd0, ovf_err}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_en", {31'd0, en_alu_rst}, 32'd0);
        chk("async_rst_tag", {28'd0, alu_rst_tag}, 32'd0);
        chk("async_rst_data", alu_rst_data, 32'd0);
        chk("async_rst_ovf", {31'd0, ovf_err}, 32'd0);
        chk("async_rst_full", {31'd0, alu_full}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cdb_grant = 1'b1;
        step();
        chk("post_rst_en", {31'd0, en_alu_rst}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
